// File: rtl/ecc_ram_pkg.sv
// Shared constants and types for the ECC data memory.
// Read-during-write modes and zeroize FSM states.
package ecc_ram_pkg;

  localparam int RD_FIRST = 0;
  localparam int WR_FIRST = 1;

  typedef enum logic {
    ZS_IDLE,
    ZS_CLEAR
  } zeroize_state_e;

endpackage

// File: rtl/ecc_ram_zeroize_ctrl.sv
// Zeroize sweep controller: walks both array halves in parallel,
// one word per port per cycle, and flags busy while clearing.
module ecc_ram_zeroize_ctrl
  import ecc_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  zeroize,
  output logic                  busy,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_addr_a,
  output logic [ADDR_WIDTH-1:0] clr_addr_b
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] HALF =
    ADDR_WIDTH'(DEPTH / 2);
  localparam logic [ADDR_WIDTH-1:0] LAST =
    HALF - ADDR_WIDTH'(1);

  zeroize_state_e        state;
  logic [ADDR_WIDTH-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ZS_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ZS_IDLE: begin
          if (zeroize) begin
            state <= ZS_CLEAR;
            cnt   <= '0;
          end
        end
        ZS_CLEAR: begin
          // A new request restarts the sweep from the bottom
          if (zeroize) begin
            cnt <= '0;
          end else if (cnt == LAST) begin
            state <= ZS_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + ADDR_WIDTH'(1);
          end
        end
        default: begin
          state <= ZS_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign busy       = (state == ZS_CLEAR);
  assign clr_we     = busy;
  assign clr_addr_a = cnt;
  assign clr_addr_b = cnt + HALF;

endmodule

// File: rtl/ecc_ram_tdp_zfile.sv
// True-dual-port ECC data RAM with zeroize sweep, optional
// output register, read-during-write mode and collision flag.
module ecc_ram_tdp_zfile
  import ecc_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int OUT_REG    = 0,
  parameter int WRITE_MODE = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  zeroize,
  input  logic                  ena,
  input  logic                  wea,
  input  logic [ADDR_WIDTH-1:0] addra,
  input  logic [DATA_WIDTH-1:0] dina,
  output logic [DATA_WIDTH-1:0] douta,
  input  logic                  enb,
  input  logic                  web,
  input  logic [ADDR_WIDTH-1:0] addrb,
  input  logic [DATA_WIDTH-1:0] dinb,
  output logic [DATA_WIDTH-1:0] doutb,
  output logic                  zeroize_busy,
  output logic                  collision
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  busy;
  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_a;
  logic [ADDR_WIDTH-1:0] clr_b;

  logic                  block;
  logic                  ea, eb, wa, wb, same;
  logic [DATA_WIDTH-1:0] rd_a, rd_b;
  logic [DATA_WIDTH-1:0] q_a, q_b, p_a, p_b;
  logic                  en_a_d, en_b_d;

  ecc_ram_zeroize_ctrl #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ctrl (
    .clk       (clk),
    .reset     (reset),
    .zeroize   (zeroize),
    .busy      (busy),
    .clr_we    (clr_we),
    .clr_addr_a(clr_a),
    .clr_addr_b(clr_b)
  );

  // User access is locked out from the request cycle onward
  assign block = zeroize | busy;
  assign ea    = ena & ~block;
  assign eb    = enb & ~block;
  assign wa    = ea & wea;
  assign wb    = eb & web;
  assign same  = (addra == addrb);

  always_comb begin
    rd_a = mem[addra];
    rd_b = mem[addrb];
    if (WRITE_MODE == WR_FIRST) begin
      if (wa)
        rd_a = dina;
      else if (wb && same)
        rd_a = dinb;
      if (wb)
        rd_b = dinb;
      else if (wa && same)
        rd_b = dina;
    end
  end

  // Port A is written last so it wins a same-address write
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_a] <= '0;
      mem[clr_b] <= '0;
    end else begin
      if (wb)
        mem[addrb] <= dinb;
      if (wa)
        mem[addra] <= dina;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || block) begin
      q_a    <= '0;
      q_b    <= '0;
      en_a_d <= 1'b0;
      en_b_d <= 1'b0;
    end else begin
      if (ea)
        q_a <= rd_a;
      if (eb)
        q_b <= rd_b;
      en_a_d <= ea;
      en_b_d <= eb;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || block) begin
      p_a <= '0;
      p_b <= '0;
    end else begin
      if (en_a_d)
        p_a <= q_a;
      if (en_b_d)
        p_b <= q_b;
    end
  end

  assign douta = (OUT_REG != 0) ? p_a : q_a;
  assign doutb = (OUT_REG != 0) ? p_b : q_b;

  always_ff @(posedge clk) begin
    if (reset)
      collision <= 1'b0;
    else
      collision <= ea & eb & same & (wea | web);
  end

  assign zeroize_busy = busy;

endmodule
